// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetchState_e;

  localparam logic [31:0] DEF_START_PC = 32'h0000_0040;
  localparam logic [31:0] DEF_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset to START_PC, loads nextPc when load is high.
module fetch_pc_reg #(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DBITS-1:0] nextPc,
  output logic [DBITS-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pc <= START_PC;
    else if (load) pc <= nextPc;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC ownership, imem req/ack, decode valid/ready, redirect kill.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int               DBITS    = 32,
  parameter logic [DBITS-1:0] START_PC = DBITS'(DEF_START_PC),
  parameter logic [DBITS-1:0] PC_STEP  = DBITS'(DEF_PC_STEP)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [DBITS-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [DBITS-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirect_target,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [DBITS-1:0] inst_out,
  output logic [DBITS-1:0] inst_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [DBITS-1:0] perf_fetch,
  output logic [DBITS-1:0] perf_stall,
  output logic [DBITS-1:0] perf_kill,
`endif
  output logic [DBITS-1:0] pc_out
);

  fetchState_e      state, stateNxt;
  logic             kill, killNxt;
  logic [DBITS-1:0] pendTarget, pendNxt;
  logic [DBITS-1:0] pcNxt;
  logic             pcLoad, capture, discard;

  fetch_pc_reg #(.DBITS(DBITS), .START_PC(START_PC)) uPcReg (
    .clk    (clk),
    .reset  (reset),
    .load   (pcLoad),
    .nextPc (pcNxt),
    .pc     (pc_out)
  );

  assign imem_req   = (state == S_REQ);
  assign imem_addr  = pc_out;
  assign inst_valid = (state == S_HOLD);

  // A response that lands while kill is set (or alongside a fresh redirect)
  // belongs to the stale path: drop it and reissue at the newest target.
  always_comb begin
    stateNxt = state;
    killNxt  = kill;
    pendNxt  = pendTarget;
    pcNxt    = pc_out;
    pcLoad   = 1'b0;
    capture  = 1'b0;
    discard  = 1'b0;
    case (state)
      S_IDLE: stateNxt = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          pcLoad = 1'b1;
          if (kill || redirect) begin
            discard = 1'b1;
            killNxt = 1'b0;
            pcNxt   = redirect ? redirect_target : pendTarget;
          end else begin
            capture  = 1'b1;
            pcNxt    = pc_out + PC_STEP;
            stateNxt = S_HOLD;
          end
        end else if (redirect) begin
          killNxt = 1'b1;
          pendNxt = redirect_target;
        end
      end
      S_HOLD: begin
        // Redirect takes priority over a same-cycle decode handshake.
        if (redirect) begin
          pcLoad   = 1'b1;
          pcNxt    = redirect_target;
          stateNxt = S_REQ;
        end else if (inst_ready) begin
          stateNxt = S_REQ;
        end
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      kill       <= 1'b0;
      pendTarget <= '0;
      inst_out   <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= stateNxt;
      kill       <= killNxt;
      pendTarget <= pendNxt;
      if (capture) begin
        inst_out <= imem_rdata;
        inst_pc  <= pc_out;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_kill  <= '0;
    end else begin
      if (inst_valid && inst_ready && !redirect) perf_fetch <= perf_fetch + 1'b1;
      if (inst_valid && !inst_ready)             perf_stall <= perf_stall + 1'b1;
      if (discard)                               perf_kill  <= perf_kill + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, ack delay, stall, kill, redirect, reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_kill;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch      (perf_fetch),
    .perf_stall      (perf_stall),
    .perf_kill       (perf_kill),
`endif
    .pc_out          (pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_target = '0; inst_ready = 1'b0;
    cyc(); cyc();
    chk("rst_req",   {31'b0, imem_req},   32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_iout",  inst_out,  32'h0);
    chk("rst_ipc",   inst_pc,   32'h0);
    chk("rst_pc",    pc_out,    32'h40);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_pfetch", perf_fetch, 32'h0);
`endif

    // Zero-wait memory, decode always ready
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1; imem_rdata = 32'h1111_0040;
    #1 chk("idle_req", {31'b0, imem_req}, 32'd0);
    cyc(); chk("seq_req0", {31'b0, imem_req}, 32'd1); chk("seq_addr0", imem_addr, 32'h40);
    cyc(); chk("seq_v0", {31'b0, inst_valid}, 32'd1); chk("seq_out0", inst_out, 32'h1111_0040);
    chk("seq_ipc0", inst_pc, 32'h40); chk("seq_pc0", pc_out, 32'h44);
    chk("seq_hreq0", {31'b0, imem_req}, 32'd0);
    imem_rdata = 32'h2222_0044;
    cyc(); chk("seq_addr1", imem_addr, 32'h44);
    cyc(); chk("seq_out1", inst_out, 32'h2222_0044); chk("seq_ipc1", inst_pc, 32'h44);
    imem_rdata = 32'h3333_0048;
    cyc(); chk("seq_addr2", imem_addr, 32'h48);
    cyc(); chk("seq_ipc2", inst_pc, 32'h48);

    // Ack delayed: request held for three cycles at 0x4C
    imem_ack = 1'b0;
    cyc(); chk("dly_addr0", imem_addr, 32'h4C); chk("dly_req0", {31'b0, imem_req}, 32'd1);
    cyc(); chk("dly_addr1", imem_addr, 32'h4C); chk("dly_v1", {31'b0, inst_valid}, 32'd0);
    cyc(); chk("dly_addr2", imem_addr, 32'h4C);
    imem_ack = 1'b1; imem_rdata = 32'h4444_004C; inst_ready = 1'b0;
    cyc(); chk("dly_out", inst_out, 32'h4444_004C); chk("dly_ipc", inst_pc, 32'h4C);
    chk("dly_pc", pc_out, 32'h50);

    // Decode stalls five cycles; word and valid must hold, no new request
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stl_v",   {31'b0, inst_valid}, 32'd1);
      chk("stl_out", inst_out, 32'h4444_004C);
      chk("stl_req", {31'b0, imem_req}, 32'd0);
    end
    inst_ready = 1'b1;

    // Redirects while request to 0x50 outstanding; last target wins
    cyc(); chk("kil_addr0", imem_addr, 32'h50);
    redirect = 1'b1; redirect_target = 32'h100;
    cyc(); chk("kil_addr1", imem_addr, 32'h50);
    redirect_target = 32'h180;
    cyc(); chk("kil_addr2", imem_addr, 32'h50); chk("kil_req2", {31'b0, imem_req}, 32'd1);
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0050;
    cyc(); chk("kil_v", {31'b0, inst_valid}, 32'd0); chk("kil_addr3", imem_addr, 32'h180);
    chk("kil_req3", {31'b0, imem_req}, 32'd1);
    imem_rdata = 32'h5555_0180;
    cyc(); chk("kil_out", inst_out, 32'h5555_0180); chk("kil_ipc", inst_pc, 32'h180);
    chk("kil_pc", pc_out, 32'h184);

    // Redirect in S_HOLD beats inst_ready
    imem_ack = 1'b0; redirect = 1'b1; redirect_target = 32'h200;
    #1 chk("hrd_v", {31'b0, inst_valid}, 32'd1);
    cyc(); chk("hrd_v1", {31'b0, inst_valid}, 32'd0); chk("hrd_addr", imem_addr, 32'h200);
    chk("hrd_pc", pc_out, 32'h200);
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h6666_0200;
    cyc(); chk("hrd_ipc", inst_pc, 32'h200); chk("hrd_pc1", pc_out, 32'h204);

    // Ack and redirect in the same cycle: data dropped
    imem_ack = 1'b0;
    cyc(); chk("same_addr0", imem_addr, 32'h204);
    imem_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h300; imem_rdata = 32'hBAD0_0204;
    cyc(); chk("same_v", {31'b0, inst_valid}, 32'd0); chk("same_addr1", imem_addr, 32'h300);
    redirect = 1'b0; inst_ready = 1'b0; imem_rdata = 32'h7777_0300;
    cyc(); chk("same_out", inst_out, 32'h7777_0300); chk("same_ipc", inst_pc, 32'h300);
    imem_ack = 1'b0;

    // Asynchronous reset while holding
    #2 reset = 1'b1;
    #1;
    chk("mrst_req",  {31'b0, imem_req},   32'd0);
    chk("mrst_v",    {31'b0, inst_valid}, 32'd0);
    chk("mrst_out",  inst_out, 32'h0);
    chk("mrst_ipc",  inst_pc,  32'h0);
    chk("mrst_pc",   pc_out,   32'h40);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_pkill", perf_kill, 32'h0);
`endif
    cyc();
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
    cyc(); chk("post_addr", imem_addr, 32'h40); chk("post_req", {31'b0, imem_req}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch datapath: owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents fetched instructions to decode over a valid/ready handshake. Handles branch/jump redirects from execute, including redirects that arrive while a memory request is outstanding. Sits between the PC register logic and decode, replacing the free-running PC write enable with controlled sequencing.

## Interface
- DBITS, 32, data/address width
- START_PC, 32'h40, PC value loaded on reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction memory request
- imem_addr  out  DBITS  request address, equals pc_out
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  DBITS  instruction word
- redirect  in  1  load redirect_target as next PC
- redirect_target  in  DBITS  redirect PC
- inst_valid  out  1  inst_out/inst_pc valid to decode
- inst_ready  in  1  decode accepts instruction
- inst_out  out  DBITS  instruction word
- inst_pc  out  DBITS  PC of inst_out
- pc_out  out  DBITS  current fetch PC

## Operation
- States: S_IDLE, S_REQ, S_HOLD. Reset: S_IDLE, pc_out=START_PC, imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, kill=0.
- S_IDLE: always -> S_REQ next cycle.
- S_REQ: imem_req=1, imem_addr=pc_out, held stable until ack.
  - ack, kill=0, no redirect: latch imem_rdata->inst_out, pc_out->inst_pc, pc_out<=pc_out+PC_STEP (mod 2^DBITS), -> S_HOLD.
  - redirect without ack: kill<=1, pending target latched; address unchanged; stay S_REQ.
  - ack with kill=1 or redirect same cycle: data discarded, pc_out<=latest target, kill<=0, stay S_REQ (new request next cycle).
- S_HOLD: inst_valid=1, imem_req=0.
  - redirect: pc_out<=redirect_target, inst_valid drops next cycle, -> S_REQ. Redirect beats inst_ready; decode must ignore a transfer in a redirect cycle.
  - inst_ready, no redirect: -> S_REQ.
- Multiple redirects while kill set: last target wins.
- Reset mid-operation: immediate return to reset values; outstanding memory response after reset is not expected (memory reset together).

## Timing
- imem_req first asserted in cycle 2 after reset release (cycle 1 = S_IDLE).
- Zero-wait memory (ack in request cycle): inst_valid one cycle after ack.
- Peak throughput: one instruction per 2 cycles (S_REQ, S_HOLD with inst_ready=1).
- Redirect in S_HOLD: request to new target in following cycle.
- pc_out update registered; visible cycle after ack/redirect.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetch (DBITS, count of delivered instructions, inst_valid&inst_ready&!redirect), perf_stall (DBITS, cycles in S_HOLD with inst_ready=0), perf_kill (DBITS, discarded responses); all reset to 0, wrap at 2^DBITS.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package fetch_ctrl_pkg: state enum (S_IDLE, S_REQ, S_HOLD), default START_PC and PC_STEP constants.
- One sub-module: fetch_pc_reg, async-reset PC register with load-enable and reset value START_PC.

## Test plan
- Reset release, ack held 1, inst_ready=1 -> imem_addr 0x40, 0x44, 0x48 on successive S_REQ cycles; inst_pc matches.
- Ack delayed 3 cycles -> imem_addr stable at 0x40 throughout, inst_out = imem_rdata sampled at ack.
- inst_ready=0 for 5 cycles in S_HOLD -> inst_valid stays 1, inst_out unchanged, no imem_req.
- Redirect to 0x100 while request to 0x44 pending, ack 2 cycles later -> response discarded, next request 0x100, inst_valid never shows the 0x44 word.
- Redirect to 0x200 in S_HOLD with inst_ready=1 -> next request 0x200, pc_out 0x200.
- Reset asserted during S_HOLD -> outputs immediately to reset values, pc_out=0x40; with FETCH_PERF_CNT_EN counters return to 0.
